// File: rtl/ibex_dbus_pkg.sv
// Shared types and helpers for the LSU data-bus to SRAM bridge.
package ibex_dbus_pkg;

  typedef struct packed {
    logic valid;
    logic err;
    logic we;
  } dbus_rsp_t;

  function automatic logic [31:0] be_to_mask(input logic [3:0] be);
    logic [31:0] mask;
    mask = '0;
    for (int i = 0; i < 4; i++) begin
      mask[8*i +: 8] = {8{be[i]}};
    end
    return mask;
  endfunction

endpackage

// File: rtl/ibex_dbus_rsp_pipe.sv
// Fixed-depth response pipe: every granted request appears at the output
// exactly Depth cycles later, in order.
module ibex_dbus_rsp_pipe
  import ibex_dbus_pkg::*;
#(
  parameter int unsigned Depth = 1
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  dbus_rsp_t rsp_i,
  output dbus_rsp_t rsp_o
);

  dbus_rsp_t stage_q [Depth];

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < Depth; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= rsp_i;
      for (int i = 1; i < Depth; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  assign rsp_o = stage_q[Depth-1];

endmodule

// File: rtl/ibex_dbus_sram_bridge.sv
// Terminates the LSU req/gnt/rvalid handshake and drives a fixed-latency
// single-port SRAM, flagging out-of-window and unaligned accesses.
module ibex_dbus_sram_bridge
  import ibex_dbus_pkg::*;
#(
  parameter int unsigned MemAw          = 14,
  parameter logic [31:0] BaseAddr       = 32'h1000_0000,
  parameter int unsigned ReadLatency    = 1,
  parameter int unsigned MaxOutstanding = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             data_req_i,
  output logic             data_gnt_o,
  input  logic [31:0]      data_addr_i,
  input  logic             data_we_i,
  input  logic [3:0]       data_be_i,
  input  logic [31:0]      data_wdata_i,
  output logic             data_rvalid_o,
  output logic [31:0]      data_rdata_o,
  output logic             data_err_o,
  input  logic             mem_stall_i,
  output logic             mem_req_o,
  output logic             mem_we_o,
  output logic [MemAw-1:0] mem_addr_o,
  output logic [31:0]      mem_wmask_o,
  output logic [31:0]      mem_wdata_o,
  input  logic [31:0]      mem_rdata_i
);

  localparam int unsigned     CntW   = $clog2(MaxOutstanding + 1);
  localparam logic [CntW-1:0] MaxCnt = CntW'(MaxOutstanding);

  logic [CntW-1:0] cnt_q;
  logic            addr_err;
  logic            rsp_retire;
  logic            no_byte_write;
  dbus_rsp_t       rsp_in;
  dbus_rsp_t       rsp_out;

  // The window is aligned to its size, so only the tag bits above the
  // word index need to match the base.
  assign addr_err = (data_addr_i[1:0] != 2'b00) |
                    (data_addr_i[31:MemAw+2] != BaseAddr[31:MemAw+2]);

  assign rsp_retire    = rsp_out.valid;
  assign no_byte_write = data_we_i & (data_be_i == 4'b0000);

  always_comb begin
    data_gnt_o = 1'b0;
    if (data_req_i && !mem_stall_i && ((cnt_q < MaxCnt) || rsp_retire)) begin
      data_gnt_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      case ({data_gnt_o, rsp_retire})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  assign mem_req_o   = data_gnt_o & ~addr_err & ~no_byte_write;
  assign mem_we_o    = data_we_i;
  assign mem_addr_o  = data_addr_i[MemAw+1:2];
  assign mem_wmask_o = be_to_mask(data_be_i);
  assign mem_wdata_o = data_wdata_i;

  always_comb begin
    rsp_in       = '0;
    rsp_in.valid = data_gnt_o;
    rsp_in.err   = addr_err;
    rsp_in.we    = data_we_i;
  end

  ibex_dbus_rsp_pipe #(
    .Depth (ReadLatency)
  ) u_rsp_pipe (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .rsp_i  (rsp_in),
    .rsp_o  (rsp_out)
  );

  // Read data is only forwarded for successful reads; the SRAM bus is
  // otherwise undefined and must not leak to the core.
  assign data_rvalid_o = rsp_out.valid;
  assign data_err_o    = rsp_out.valid & rsp_out.err;
  assign data_rdata_o  = (rsp_out.valid & ~rsp_out.err & ~rsp_out.we) ? mem_rdata_i : 32'h0;

endmodule

// File: tb/tb_ibex_dbus_sram_bridge.sv
// Three bridge configurations share one randomized LSU stimulus stream and are
// each checked every cycle against a cycle-scheduled response model.
module tb_ibex_dbus_sram_bridge;

  localparam logic [31:0] Base = 32'h1000_0000;
  localparam int          Win  = 4 * (1 << 14);

  logic        clk;
  logic        rst_n;
  logic        req;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        stall;

  logic        gnt    [3];
  logic        rvalid [3];
  logic        err    [3];
  logic        mreq   [3];
  logic        mwe    [3];
  logic [31:0] rdata  [3];
  logic [31:0] mwmask [3];
  logic [31:0] mwdata [3];
  logic [31:0] mrdata [3];
  logic [13:0] maddr  [3];
  logic [1:0]  cnt_obs[3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  function automatic int rl_of(input int i);
    return (i == 0) ? 1 : 2;
  endfunction

  function automatic int mx_of(input int i);
    return (i == 2) ? 1 : 2;
  endfunction

  function automatic logic [31:0] bg_word(input int k);
    if (k == 4) return 32'hDEAD_BEEF;
    return (32'(k) * 32'h0103_0507) ^ 32'hA5A5_5A5A;
  endfunction

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Instances: (ReadLatency, MaxOutstanding) = (1,2), (2,2), (2,1); each with
  // its own SRAM that re-initialises to the background pattern on reset.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int unsigned Rl = (g == 0) ? 1 : 2;
    localparam int unsigned Mx = (g == 2) ? 1 : 2;
    logic [31:0] sram [16];
    logic [31:0] p1;
    logic [31:0] p2;

    ibex_dbus_sram_bridge #(
      .MemAw          (14),
      .BaseAddr       (Base),
      .ReadLatency    (Rl),
      .MaxOutstanding (Mx)
    ) u_dut (
      .clk_i         (clk),
      .rst_ni        (rst_n),
      .data_req_i    (req),
      .data_gnt_o    (gnt[g]),
      .data_addr_i   (addr),
      .data_we_i     (we),
      .data_be_i     (be),
      .data_wdata_i  (wdata),
      .data_rvalid_o (rvalid[g]),
      .data_rdata_o  (rdata[g]),
      .data_err_o    (err[g]),
      .mem_stall_i   (stall),
      .mem_req_o     (mreq[g]),
      .mem_we_o      (mwe[g]),
      .mem_addr_o    (maddr[g]),
      .mem_wmask_o   (mwmask[g]),
      .mem_wdata_o   (mwdata[g]),
      .mem_rdata_i   (mrdata[g])
    );

    assign cnt_obs[g] = 2'(u_dut.cnt_q);

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int k = 0; k < 16; k++) sram[k] <= bg_word(k);
        p1 <= 32'h0;
        p2 <= 32'h0;
      end else begin
        if (mreq[g] && mwe[g])
          sram[maddr[g][3:0]] <= (sram[maddr[g][3:0]] & ~mwmask[g]) | (mwdata[g] & mwmask[g]);
        if (mreq[g] && !mwe[g]) p1 <= sram[maddr[g][3:0]];
        else                    p1 <= $urandom;
        p2 <= p1;
      end
    end

    if (Rl == 1) begin : g_l1
      assign mrdata[g] = p1;
    end else begin : g_l2
      assign mrdata[g] = p2;
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [31:0] a, input logic w,
                               input logic [3:0] b, input logic [31:0] d, input logic s);
    @(posedge clk);
    #1;
    req = r; addr = a; we = w; be = b; wdata = d; stall = s;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 32'h0, 1'b0, 4'h0, 32'h0, 1'b0);
  endtask

  // Reference model: responses are scheduled into the cycle they are due,
  // outstanding count and SRAM contents are tracked per instance.
  initial begin : model
    bit          ev   [3][4];
    bit          eerr [3][4];
    logic [31:0] erd  [3][4];
    logic [31:0] shadow [3][16];
    int          cnt  [3];
    bit          m_gnt [3];
    bit          m_err [3];
    bit          m_ret [3];
    bit          m_mreq[3];
    int          m_word[3];
    bit          was_rst;
    logic [31:0] mask;
    int          s;
    int          t;
    forever begin
      @(negedge clk);
      was_rst = !rst_n;
      s = cyc % 4;
      mask = '0;
      for (int b = 0; b < 4; b++) if (be[b]) mask[8*b +: 8] = 8'hFF;
      for (int i = 0; i < 3; i++) begin
        if (was_rst) begin
          for (int k = 0; k < 4; k++) ev[i][k] = 0;
          for (int k = 0; k < 16; k++) shadow[i][k] = bg_word(k);
          cnt[i] = 0;
          checkOutput($sformatf("rst_gnt[%0d]", i), 32'(gnt[i]), 32'h0);
          checkOutput($sformatf("rst_rvalid[%0d]", i), 32'(rvalid[i]), 32'h0);
          checkOutput($sformatf("rst_err[%0d]", i), 32'(err[i]), 32'h0);
          checkOutput($sformatf("rst_mreq[%0d]", i), 32'(mreq[i]), 32'h0);
          checkOutput($sformatf("rst_rdata[%0d]", i), rdata[i], 32'h0);
          checkOutput($sformatf("rst_cnt[%0d]", i), 32'(cnt_obs[i]), 32'h0);
        end else begin
          m_ret[i]  = ev[i][s];
          m_err[i]  = (addr[1:0] != 2'b00) || (addr < Base) || ((addr - Base) >= 32'(Win));
          m_word[i] = int'((addr - Base) >> 2);
          m_gnt[i]  = req && !stall && ((cnt[i] < mx_of(i)) || m_ret[i]);
          m_mreq[i] = m_gnt[i] && !m_err[i] && !(we && be == 4'h0);
          checkOutput($sformatf("cnt[%0d]", i), 32'(cnt_obs[i]), 32'(cnt[i]));
          checkOutput($sformatf("gnt[%0d]", i), 32'(gnt[i]), 32'(m_gnt[i]));
          checkOutput($sformatf("mreq[%0d]", i), 32'(mreq[i]), 32'(m_mreq[i]));
          if (m_mreq[i]) begin
            checkOutput($sformatf("maddr[%0d]", i), 32'(maddr[i]), 32'(m_word[i]));
            checkOutput($sformatf("mwe[%0d]", i), 32'(mwe[i]), 32'(we));
            if (we) begin
              checkOutput($sformatf("mwmask[%0d]", i), mwmask[i], mask);
              checkOutput($sformatf("mwdata[%0d]", i), mwdata[i], wdata);
            end
          end
          checkOutput($sformatf("rvalid[%0d]", i), 32'(rvalid[i]), 32'(m_ret[i]));
          checkOutput($sformatf("rdata[%0d]", i), rdata[i], m_ret[i] ? erd[i][s] : 32'h0);
          if (m_ret[i]) checkOutput($sformatf("err[%0d]", i), 32'(err[i]), 32'(eerr[i][s]));
        end
      end
      @(posedge clk);
      if (!was_rst) begin
        for (int i = 0; i < 3; i++) begin
          ev[i][s] = 0;
          if (m_gnt[i]) begin
            t = (cyc + rl_of(i)) % 4;
            ev[i][t]   = 1;
            eerr[i][t] = m_err[i];
            erd[i][t]  = (m_err[i] || we) ? 32'h0 : shadow[i][m_word[i] % 16];
            if (!m_err[i] && we)
              shadow[i][m_word[i] % 16] = (shadow[i][m_word[i] % 16] & ~mask) | (wdata & mask);
          end
          cnt[i] = cnt[i] + int'(m_gnt[i]) - int'(m_ret[i]);
        end
      end
      cyc++;
    end
  end

  initial begin : stim
    logic [31:0] err_addrs [3];
    logic [31:0] r_addr;
    int          cat;
    err_addrs[0] = 32'h0FFF_FFFC;
    err_addrs[1] = 32'h1001_0000;
    err_addrs[2] = 32'h1000_0002;
    rst_n = 1'b0;
    req = 1'b0; addr = 32'h0; we = 1'b0; be = 4'h0; wdata = 32'h0; stall = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    idle(2);

    // Aligned read of word 4
    applyStimulus(1'b1, 32'h1000_0010, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("rd_gnt", 32'(gnt[0]), 32'h1);
    checkOutput("rd_maddr", 32'(maddr[0]), 32'h4);
    idle(1);
    @(negedge clk);
    checkOutput("rd_rvalid_l1", 32'(rvalid[0]), 32'h1);
    checkOutput("rd_rdata_l1", rdata[0], 32'hDEAD_BEEF);
    checkOutput("rd_err_l1", 32'(err[0]), 32'h0);
    idle(1);
    @(negedge clk);
    checkOutput("rd_rdata_l2", rdata[1], 32'hDEAD_BEEF);

    // Byte write into lane 2 of word 2, then read it back
    idle(2);
    applyStimulus(1'b1, 32'h1000_0008, 1'b1, 4'b0100, 32'h00AB_0000, 1'b0);
    @(negedge clk);
    checkOutput("wr_mask", mwmask[0], 32'h00FF_0000);
    applyStimulus(1'b1, 32'h1000_0008, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("wr_rvalid", 32'(rvalid[0]), 32'h1);
    checkOutput("wr_rdata", rdata[0], 32'h0);
    idle(1);
    @(negedge clk);
    checkOutput("wr_byte2", {24'h0, rdata[0][23:16]}, 32'h0000_00AB);

    // Back-to-back split pair and a third request
    idle(3);
    applyStimulus(1'b1, 32'h1000_0004, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("split_gnt0_l2", 32'(gnt[1]), 32'h1);
    checkOutput("split_gnt0_m1", 32'(gnt[2]), 32'h1);
    applyStimulus(1'b1, 32'h1000_000C, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("split_gnt1_l2", 32'(gnt[1]), 32'h1);
    checkOutput("split_hold_m1", 32'(gnt[2]), 32'h0);
    applyStimulus(1'b1, 32'h1000_0014, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("split_cnt2", 32'(cnt_obs[1]), 32'h2);
    checkOutput("split_rv_first", 32'(rvalid[1]), 32'h1);
    checkOutput("split_gnt2_retire", 32'(gnt[1]), 32'h1);
    checkOutput("split_gnt_m1_after", 32'(gnt[2]), 32'h1);

    // Decode errors
    idle(3);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, err_addrs[k], 1'b0, 4'hF, 32'h0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("err%0d_gnt", k), 32'(gnt[0]), 32'h1);
      checkOutput($sformatf("err%0d_mreq", k), 32'(mreq[0]), 32'h0);
      idle(1);
      @(negedge clk);
      checkOutput($sformatf("err%0d_rvalid", k), 32'(rvalid[0]), 32'h1);
      checkOutput($sformatf("err%0d_err", k), 32'(err[0]), 32'h1);
      checkOutput($sformatf("err%0d_rdata", k), rdata[0], 32'h0);
    end

    // Stall with a response in flight
    idle(3);
    applyStimulus(1'b1, 32'h1000_0018, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("stall_pre_gnt", 32'(gnt[1]), 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b1, 32'h1000_001C, 1'b0, 4'hF, 32'h0, 1'b1);
      @(negedge clk);
      checkOutput($sformatf("stall%0d_gnt", k), 32'(gnt[1]), 32'h0);
      checkOutput($sformatf("stall%0d_mreq", k), 32'(mreq[1]), 32'h0);
      if (k == 1) checkOutput("stall_rvalid_ontime", 32'(rvalid[1]), 32'h1);
    end
    applyStimulus(1'b1, 32'h1000_001C, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("stall_release_gnt", 32'(gnt[1]), 32'h1);

    // Reset one cycle after a grant
    idle(3);
    applyStimulus(1'b1, 32'h1000_0020, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("mrst_gnt", 32'(gnt[1]), 32'h1);
    @(posedge clk);
    #1;
    rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    checkOutput("mrst_cnt", 32'(cnt_obs[1]), 32'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checkOutput($sformatf("mrst_norv%0d", k), 32'(rvalid[1]), 32'h0);
      idle(1);
    end
    applyStimulus(1'b1, 32'h1000_0024, 1'b0, 4'hF, 32'h0, 1'b0);
    @(negedge clk);
    checkOutput("mrst_next_gnt", 32'(gnt[1]), 32'h1);

    // Randomized traffic
    for (int n = 0; n < 800; n++) begin
      cat = int'($urandom_range(0, 9));
      if (cat < 7)       r_addr = Base + 32'($urandom_range(0, 15)) * 4;
      else if (cat == 7) r_addr = Base + 32'($urandom_range(0, 63)) | 32'h1;
      else if (cat == 8) r_addr = Base - 32'($urandom_range(1, 16)) * 4;
      else               r_addr = Base + 32'(Win) + 32'($urandom_range(0, 16)) * 4;
      applyStimulus($urandom_range(0, 3) != 0, r_addr, 1'($urandom),
                    4'($urandom), $urandom, $urandom_range(0, 6) == 0);
    end
    idle(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
